// File: rtl/datapath_src_sel51_ctrl_if.sv
// Handshake and configuration bundle between the 5:1 source mux, its selection controller and the consumer.
interface datapath_src_sel51_ctrl_if #(
  parameter int unsigned BL_W = 8
);
  logic [4:0]      src_valid;
  logic [4:0]      cfg_src_en;
  logic [BL_W-1:0] cfg_burst_len;
  logic [2:0]      S;
  logic            mux_z_valid;
  logic            mux_z_ready;
  logic            dn_valid;
  logic            dn_ready;
  logic            grant_active;
  logic [BL_W-1:0] beat_cnt;

  modport master (
    output src_valid, cfg_src_en, cfg_burst_len, mux_z_valid, dn_ready,
    input  S, mux_z_ready, dn_valid, grant_active, beat_cnt
  );

  modport slave (
    input  src_valid, cfg_src_en, cfg_burst_len, mux_z_valid, dn_ready,
    output S, mux_z_ready, dn_valid, grant_active, beat_cnt
  );
endinterface

// File: rtl/datapath_src_sel51_ctrl.sv
// Burst-locked round-robin select controller for the 5:1 valid/ready source mux.
// Optional stall timeout on a locked grant is enabled with `define SRC_SEL_TIMEOUT_EN.
module datapath_src_sel51_ctrl #(
  parameter int unsigned BL_W        = 8,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  datapath_src_sel51_ctrl_if.slave    bus
);

  localparam int unsigned N_SRC = 5;
  localparam int unsigned SEL_W = 3;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  s_q, s_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic [BL_W-1:0]   beat_q, beat_d;
  logic [BL_W-1:0]   len_q, len_d;

  logic [N_SRC-1:0]  elig_c;
  logic              win_vld_c;
  logic [SEL_W-1:0]  win_c;
  logic              active_c;
  logic              fire_c;
  logic              arb_c;

  assign elig_c   = bus.src_valid & bus.cfg_src_en;
  assign active_c = (state_q == LOCK);
  assign fire_c   = bus.mux_z_valid & bus.dn_ready & active_c;

  assign bus.S            = s_q;
  assign bus.grant_active = active_c;
  assign bus.beat_cnt     = beat_q;
  assign bus.dn_valid     = bus.mux_z_valid & active_c;
  assign bus.mux_z_ready  = bus.dn_ready & active_c;

  // Round-robin pick: scan farthest-first so the nearest eligible source after last_q wins.
  always_comb begin
    logic [SEL_W-1:0] idx;
    win_vld_c = 1'b0;
    win_c     = last_q;
    idx       = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = SEL_W'((int'(last_q) + k) % int'(N_SRC));
      if (elig_c[idx]) begin
        win_vld_c = 1'b1;
        win_c     = idx;
      end
    end
  end

`ifdef SRC_SEL_TIMEOUT_EN
  localparam int unsigned ST_W = $clog2(TIMEOUT_CYC);
  logic [ST_W-1:0] stall_q, stall_d;
  logic            stall_exp_c;

  assign stall_exp_c = active_c & ~fire_c & (stall_q == ST_W'(TIMEOUT_CYC - 1));
  assign stall_d     = (active_c && !fire_c && !arb_c) ? stall_q + ST_W'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end
`else
  logic stall_exp_c;
  assign stall_exp_c = 1'b0;
`endif

  // Next-state: arbitrate from IDLE, or on a last-beat fire / stall expiry while locked.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    last_d  = last_q;
    beat_d  = beat_q;
    len_d   = len_q;
    arb_c   = 1'b0;

    unique case (state_q)
      IDLE: arb_c = 1'b1;
      LOCK: begin
        if (fire_c) begin
          if (beat_q == len_q - BL_W'(1)) arb_c  = 1'b1;
          else                            beat_d = beat_q + BL_W'(1);
        end else if (stall_exp_c) begin
          arb_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb_c) begin
      beat_d = '0;
      if (win_vld_c) begin
        state_d = LOCK;
        s_d     = win_c;
        last_d  = win_c;
        len_d   = (bus.cfg_burst_len == '0) ? BL_W'(1) : bus.cfg_burst_len;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      last_q  <= SEL_W'(N_SRC - 1);
      beat_q  <= '0;
      len_q   <= BL_W'(1);
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_datapath_src_sel51_ctrl.sv
// Directed bench for datapath_src_sel51_ctrl with a cycle-level reference model and literal spot checks.
module tb_datapath_src_sel51_ctrl;

  localparam int unsigned BL_W = 8;
  localparam int unsigned TO   = 8;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  datapath_src_sel51_ctrl_if #(.BL_W(BL_W)) bus ();

  datapath_src_sel51_ctrl #(.BL_W(BL_W), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    else             n_pass++;
  endtask

  // Reference model: owner/beats-done/stall-run, advanced once per clock.
  bit m_locked;
  int m_owner, m_last, m_beats, m_len, m_stall, m_pick;
  bit m_fire, m_done;

  function automatic int rr_pick(input logic [4:0] el, input int last);
    for (int k = 1; k <= 5; k++)
      if (el[3'((last + k) % 5)]) return (last + k) % 5;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_locked = 1'b0; m_owner = 0; m_last = 4; m_beats = 0; m_len = 1; m_stall = 0;
    end else begin
      m_fire = bus.mux_z_valid && bus.dn_ready && m_locked;
      m_done = !m_locked;
      if (m_locked) begin
        if (m_fire) begin
          m_beats++;
          m_stall = 0;
          if (m_beats == m_len) m_done = 1'b1;
        end else begin
          m_stall++;
`ifdef SRC_SEL_TIMEOUT_EN
          if (m_stall == TO) m_done = 1'b1;
`endif
        end
      end
      if (m_done) begin
        m_pick  = rr_pick(bus.src_valid & bus.cfg_src_en, m_last);
        m_beats = 0;
        m_stall = 0;
        if (m_pick >= 0) begin
          m_locked = 1'b1;
          m_owner  = m_pick;
          m_last   = m_pick;
          m_len    = (bus.cfg_burst_len == 0) ? 1 : int'(bus.cfg_burst_len);
        end else begin
          m_locked = 1'b0;
        end
      end
    end
  end

  // Compare every cycle, mid-period, while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("S",            32'(bus.S),            32'(m_owner));
      chk("grant_active", 32'(bus.grant_active), 32'(m_locked));
      chk("beat_cnt",     32'(bus.beat_cnt),     32'(m_beats));
      chk("dn_valid",     32'(bus.dn_valid),     32'(bus.mux_z_valid & m_locked));
      chk("mux_z_ready",  32'(bus.mux_z_ready),  32'(bus.dn_ready & m_locked));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic set_in(input logic [4:0] v, input logic [4:0] en, input int len,
                        input logic zv, input logic rdy);
    bus.src_valid     = v;
    bus.cfg_src_en    = en;
    bus.cfg_burst_len = BL_W'(len);
    bus.mux_z_valid   = zv;
    bus.dn_ready      = rdy;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    set_in(5'b00000, 5'b11111, 4, 1'b1, 1'b1);
    #1;
    // Reset values with upstream valid and downstream ready both high.
    chk("rst_S",        32'(bus.S),            0);
    chk("rst_grant",    32'(bus.grant_active), 0);
    chk("rst_beat",     32'(bus.beat_cnt),     0);
    chk("rst_dn_valid", 32'(bus.dn_valid),     0);
    chk("rst_z_ready",  32'(bus.mux_z_ready),  0);
    step(2);
    rst_n = 1'b1;

    // T1: single source A, burst of 4, released after the 4th fire.
    set_in(5'b00001, 5'b11111, 4, 1'b1, 1'b1);
    step(1);
    chk("t1_S",     32'(bus.S), 0);
    chk("t1_grant", 32'(bus.grant_active), 1);
    bus.src_valid = 5'b00000;
    step(3);
    chk("t1_beat3", 32'(bus.beat_cnt), 3);
    chk("t1_held",  32'(bus.grant_active), 1);
    step(1);
    chk("t1_rel",   32'(bus.grant_active), 0);
    chk("t1_beat0", 32'(bus.beat_cnt), 0);

    // T2: all sources, burst 2, back-to-back rotation.
    do_reset();
    set_in(5'b11111, 5'b11111, 2, 1'b1, 1'b1);
    step(1);
    chk("t2_S0", 32'(bus.S), 0);
    for (int i = 1; i <= 5; i++) begin
      step(2);
      chk("t2_S",     32'(bus.S), 32'(i % 5));
      chk("t2_grant", 32'(bus.grant_active), 1);
    end

    // T3: consumer stall mid-burst freezes the burst.
    do_reset();
    set_in(5'b11111, 5'b11111, 4, 1'b1, 1'b1);
    step(2);
    chk("t3_beat1", 32'(bus.beat_cnt), 1);
    bus.dn_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t3_S",      32'(bus.S), 0);
      chk("t3_frozen", 32'(bus.beat_cnt), 1);
      chk("t3_zrdy",   32'(bus.mux_z_ready), 0);
    end
    bus.dn_ready = 1'b1;
    step(2);
    chk("t3_beat3", 32'(bus.beat_cnt), 3);
    step(1);
    chk("t3_next",  32'(bus.S), 1);

    // T4: only B, C, E enabled.
    do_reset();
    set_in(5'b11111, 5'b10110, 1, 1'b1, 1'b1);
    step(1); chk("t4_B",  32'(bus.S), 1);
    step(1); chk("t4_C",  32'(bus.S), 2);
    step(1); chk("t4_E",  32'(bus.S), 4);
    step(1); chk("t4_B2", 32'(bus.S), 1);

    // T5: zero length means one beat; then async reset mid-burst.
    do_reset();
    set_in(5'b11111, 5'b11111, 0, 1'b1, 1'b1);
    step(1); chk("t5_A", 32'(bus.S), 0);
    step(1); chk("t5_B", 32'(bus.S), 1);
    step(1); chk("t5_C", 32'(bus.S), 2);
    bus.cfg_burst_len = BL_W'(4);
    step(1); chk("t5_D", 32'(bus.S), 3);
    step(2); chk("t5_beat2", 32'(bus.beat_cnt), 2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_S",     32'(bus.S), 0);
    chk("t5_rst_grant", 32'(bus.grant_active), 0);
    chk("t5_rst_beat",  32'(bus.beat_cnt), 0);
    chk("t5_rst_zrdy",  32'(bus.mux_z_ready), 0);
    step(1);
    rst_n = 1'b1;

    // T6: locked source goes silent while B waits.
    do_reset();
    set_in(5'b00001, 5'b11111, 4, 1'b1, 1'b1);
    step(1);
    chk("t6_A", 32'(bus.S), 0);
    bus.src_valid   = 5'b00010;
    bus.mux_z_valid = 1'b0;
    step(TO - 1);
    chk("t6_hold", 32'(bus.S), 0);
    step(1);
`ifdef SRC_SEL_TIMEOUT_EN
    chk("t6_to_B",     32'(bus.S), 1);
    chk("t6_to_grant", 32'(bus.grant_active), 1);
    chk("t6_to_beat",  32'(bus.beat_cnt), 0);
`else
    step(12);
    chk("t6_still_A",     32'(bus.S), 0);
    chk("t6_still_grant", 32'(bus.grant_active), 1);
`endif

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
